// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NREAD combinational read ports, two write
// lanes with same-cycle bypass, hardwired zero register, busy scoreboard and bulk clear.
module reg_file_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned NREAD    = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    wen0,
    input  logic                    wen1,
    input  logic [AW-1:0]           waddr0,
    input  logic [AW-1:0]           waddr1,
    input  logic [XLEN-1:0]         wdata0,
    input  logic [XLEN-1:0]         wdata1,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_addr,
    input  logic                    flush,
    input  logic                    clr_start,
    output logic                    clr_busy
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_CLEAR = 1'b1;
    localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            we0_eff, we1_eff;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    assign clr_busy = (state_q == ST_CLEAR);
    assign we0_eff  = wen0 && !is_zero(waddr0) && !clr_busy;
    assign we1_eff  = wen1 && !is_zero(waddr1) && !clr_busy;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (clr_busy) begin
            regs_d[cnt_q] = '0;
        end else begin
            if (we0_eff) regs_d[waddr0] = wdata0;
            // Lane 1 is applied last so it wins an address conflict.
            if (we1_eff) regs_d[waddr1] = wdata1;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (wen0) busy_d[waddr0] = 1'b0;
        if (wen1) busy_d[waddr1] = 1'b0;
        // Set after clear: a newly issued producer supersedes the retiring one.
        if (iss_valid && !is_zero(iss_addr)) busy_d[iss_addr] = 1'b1;
        if (flush) busy_d = '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (clr_start) begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = ST_IDLE;
        end
    end

    always_comb begin : rd_mux
        logic [AW-1:0] a;
        a       = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            a = rd_addr[i*AW +: AW];
            if (is_zero(a))
                rd_data[i*XLEN +: XLEN] = '0;
            else if (we1_eff && waddr1 == a)
                rd_data[i*XLEN +: XLEN] = wdata1;
            else if (we0_eff && waddr0 == a)
                rd_data[i*XLEN +: XLEN] = wdata0;
            else
                rd_data[i*XLEN +: XLEN] = regs_q[a];
            rd_busy[i] = busy_q[a] && !(wen0 && waddr0 == a) && !(wen1 && waddr1 == a);
        end
    end

    // NOTE: the whole array is reset because unwritten registers must read back as zero.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
            busy_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file for the pipelined core: NREAD read ports, two write ports with same-cycle write-through bypass, a hardwired zero register, a per-register busy scoreboard for hazard detection, and a sequential bulk-clear engine. It sits between decode (reads, issue marking) and writeback (two retire lanes).

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥4)
- AW, 5, address width, equal to log2(NREG)
- NREAD, 2, number of read ports (1–4)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; clears all registers, busy bits and the clear engine
- rd_addr  in  NREAD*AW  read addresses, port i at bits [i*AW +: AW]
- rd_data  out  NREAD*XLEN  read data, combinational, port i at bits [i*XLEN +: XLEN]
- rd_busy  out  NREAD  busy bit of each read address, combinational
- wen0, wen1  in  1  write enables, lanes 0 and 1
- waddr0, waddr1  in  AW  write addresses
- wdata0, wdata1  in  XLEN  write data
- iss_valid  in  1  marks iss_addr busy (producer issued)
- iss_addr  in  AW  destination register being issued
- flush  in  1  synchronously clears all busy bits
- clr_start  in  1  starts the bulk-clear sequence
- clr_busy  out  1  high while bulk clear is in progress

## Operation
- Write: an effective write to `regs[waddrN]` requires wenN=1, ZERO_REG=0 or waddrN≠0, and clr_busy=0.
- Write conflict: if both lanes write the same address in the same cycle, lane 1 wins.
- Read: rd_data[i] comes from lane 1's effective write when its address matches rd_addr[i]. Otherwise it comes from lane 0's effective write when that address matches. Otherwise it is `regs[rd_addr[i]]`. Address 0 with ZERO_REG=1 always reads 0.
- Bypass is disabled while clr_busy=1.
- Scoreboard: busy[a] is set by iss_valid with iss_addr=a, and is cleared by any wenN with waddrN=a. These rules apply even during a bulk clear.
- Set and clear of the same address in the same cycle: set wins (a newer producer is issued).
- flush clears all busy bits and overrides a same-cycle iss_valid.
- busy[0] is never set when ZERO_REG=1.
- rd_busy[i] is busy[rd_addr[i]] before the edge. A same-cycle clearing write forces rd_busy[i]=0, consistent with the bypassed data.
- Clear engine FSM:
  - IDLE: on clr_start, go to CLEAR with cnt=0.
  - CLEAR: write 0 to regs[cnt] and increment cnt. After cnt=NREG-1 is written, return to IDLE.
  - clr_start while in CLEAR is ignored.
  - Writes arriving during CLEAR are dropped. No error is flagged; the pipeline must stall on clr_busy.

## Timing
- Read latency: 0 cycles, combinational from rd_addr, wen*, waddr* and wdata*.
- Write latency: 1 cycle; the new value is visible in regs after the edge, and bypassed in the same cycle.
- Busy latency: iss_valid in cycle t makes rd_busy=1 from cycle t+1.
- Bulk clear: clr_busy rises the cycle after clr_start and stays high for exactly NREG cycles. The first write accepted after the clear is in the cycle clr_busy is low.
- Reset values: all regs 0, all busy 0, FSM IDLE, cnt 0, clr_busy 0, rd_busy 0. rd_data is 0 for every address.
- Reset asserted mid-clear aborts the clear immediately. Since all regs are zeroed anyway, there is no partial state.
- cnt wrap: cnt is AW bits wide and wraps to 0 on exit from CLEAR.

## Test plan
- Reset then read: deassert reset, read all 32 addresses on both ports -> every rd_data 0 and every rd_busy 0.
- Dual write, same address: wen0=wen1=1, waddr=5, wdata0=0x11, wdata1=0x22, rd_addr0=5 -> rd_data 0x22 in the same cycle, and regs[5]=0x22 next cycle.
- Zero register: wen0=1, waddr0=0, wdata0=0xDEADBEEF, rd_addr=0 -> rd_data 0 in the same cycle and the next.
- Scoreboard: iss_valid with iss_addr=7 at t -> rd_busy=1 at t+1. Then at t+3, wen1 to 7 together with iss_valid to 7 -> busy stays 1. Then flush -> busy 0 next cycle.
- Bulk clear: preload regs 1..31 with their index, pulse clr_start, attempt wen0 to 3 mid-clear -> clr_busy high for 32 cycles and all regs 0 afterwards, with the write dropped.
- Reset mid-clear: assert reset at cycle 10 of CLEAR -> clr_busy 0 immediately, all regs 0, FSM IDLE.
